fdiv_ratio_ctrl: RTL and testbench

//  Upstream control stage for the programmable 50%-duty clock divider. Accepts new

---
 rtl/fdiv_ratio_ctrl.sv | 111 +++++++++++
 tb/tb_fdiv_ratio_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_ratio_ctrl.sv
// Ratio control for the 50%-duty clock divider: host ratio updates and sweeps,
// applied to n_out only on divider-period boundaries.
module fdiv_ratio_ctrl #(
    parameter int N_RESET = 2,
    parameter int N_MIN   = 2,
    parameter int DWELL   = 4
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_n,
    input  logic       cfg_sweep,
    input  logic [7:0] cfg_stop,
    input  logic       cfg_abort,
    output logic [7:0] n_out,
    output logic       period_start,
    output logic       busy,
    output logic       err_clamp
);
    localparam int         DW    = $clog2(DWELL + 1);
    localparam logic [7:0] NMIN8 = 8'(N_MIN);

    typedef enum logic [1:0] {IDLE, PEND, SWEEP} state_t;

    state_t          state_q, state_d;
    logic [7:0]      n_q, n_d;
    logic [7:0]      pcnt_q, pcnt_d;
    logic [7:0]      tgt_q, tgt_d;
    logic [7:0]      stop_q, stop_d;
    logic            sweep_q, sweep_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic            err_q, err_d;
    logic            boundary;

    assign boundary     = (pcnt_q == n_q - 8'd1);
    assign period_start = boundary;
    assign cfg_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign n_out        = n_q;
    assign err_clamp    = err_q;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        tgt_d   = tgt_q;
        stop_d  = stop_q;
        sweep_d = sweep_q;
        dwell_d = dwell_q;
        err_d   = err_q;
        // pcnt wraps on the boundary edge, so a new n_out starts from pcnt=0
        pcnt_d  = boundary ? 8'd0 : pcnt_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    tgt_d   = (cfg_n < NMIN8) ? NMIN8 : cfg_n;
                    stop_d  = (cfg_stop < NMIN8) ? NMIN8 : cfg_stop;
                    sweep_d = cfg_sweep;
                    err_d   = (cfg_n < NMIN8) | (cfg_sweep & (cfg_stop < NMIN8));
                    state_d = PEND;
                end
            end
            PEND: begin
                if (cfg_abort) begin
                    state_d = IDLE;
                end else if (boundary) begin
                    n_d     = tgt_q;
                    dwell_d = '0;
                    state_d = (sweep_q && (tgt_q != stop_q)) ? SWEEP : IDLE;
                end
            end
            SWEEP: begin
                if (cfg_abort) begin
                    state_d = IDLE;
                end else if (boundary) begin
                    if (dwell_q == DW'(DWELL - 1)) begin
                        dwell_d = '0;
                        n_d     = (n_q < stop_q) ? n_q + 8'd1 : n_q - 8'd1;
                        if (n_d == stop_q) state_d = IDLE;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= 8'(N_RESET);
            pcnt_q  <= 8'd0;
            tgt_q   <= 8'(N_RESET);
            stop_q  <= 8'(N_RESET);
            sweep_q <= 1'b0;
            dwell_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            pcnt_q  <= pcnt_d;
            tgt_q   <= tgt_d;
            stop_q  <= stop_d;
            sweep_q <= sweep_d;
            dwell_q <= dwell_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_fdiv_ratio_ctrl.sv
// Scoreboard bench: each request pushes the n_out changes it should cause
// (value and cycle); a negedge monitor pops and compares every observed change.
module tb_fdiv_ratio_ctrl;
    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_n = 8'd0;
    logic       cfg_sweep = 1'b0;
    logic [7:0] cfg_stop = 8'd0;
    logic       cfg_abort = 1'b0;
    logic [7:0] n_out;
    logic       period_start;
    logic       busy;
    logic       err_clamp;

    fdiv_ratio_ctrl #(.N_RESET(2), .N_MIN(2), .DWELL(4)) dut (
        .clk_in(clk_in), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_n(cfg_n), .cfg_sweep(cfg_sweep), .cfg_stop(cfg_stop), .cfg_abort(cfg_abort),
        .n_out(n_out), .period_start(period_start), .busy(busy), .err_clamp(err_clamp)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int n;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   prev_n = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (mon_en && (int'(n_out) != prev_n)) begin
            if (sb.size() == 0) begin
                chk("unexpected_n_change", int'(n_out), prev_n);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("n_value", int'(n_out), e.n);
                chk("n_cycle", cyc, e.cyc);
            end
        end
        prev_n = int'(n_out);
    end

    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    // Leaves us in the cycle whose upcoming edge is a period boundary.
    task automatic sync_boundary();
        bit found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (period_start) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk("sync_timeout", 0, 1);
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0) break;
            step();
        end
        chk(tag, sb.size(), 0);
    endtask

    task automatic measure_period(input string tag, input int exp);
        int cnt = 0;
        sync_boundary();
        for (int i = 0; i < 300; i++) begin
            step();
            cnt++;
            if (period_start) break;
        end
        chk(tag, cnt, exp);
    endtask

    // Syncs, moves one cycle past the boundary, then issues a request that is
    // accepted mid-period. Returns the cycle index just before the accept edge.
    task automatic issue(input int n, input bit sw, input int stop, output int c0);
        sync_boundary();
        step();
        c0        = cyc;
        cfg_valid = 1'b1;
        cfg_n     = 8'(n);
        cfg_sweep = sw;
        cfg_stop  = 8'(stop);
        step();
        cfg_valid = 1'b0;
    endtask

    int c0;

    initial begin
        exp_t e;
        // reset
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst = 1'b0;
        #1;
        chk("rst_n_out", int'(n_out), 2);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_err_clamp", int'(err_clamp), 0);
        chk("rst_period_start", int'(period_start), 0);
        mon_en = 1'b1;
        measure_period("rst_period", 2);

        // single update to 5, accepted mid-period
        issue(5, 1'b0, 0, c0);
        chk("single_busy", int'(busy), 1);
        chk("single_ready", int'(cfg_ready), 0);
        e.n = 5; e.cyc = c0 + 2; sb.push_back(e);
        wait_empty("single_wait");
        chk("single_idle_busy", int'(busy), 0);
        measure_period("single_period", 5);

        // clamp below N_MIN, then a legal request clears the flag
        issue(0, 1'b0, 0, c0);
        chk("clamp_err_set", int'(err_clamp), 1);
        e.n = 2; e.cyc = c0 + 5; sb.push_back(e);
        wait_empty("clamp_wait");
        chk("clamp_err_hold", int'(err_clamp), 1);
        issue(7, 1'b0, 0, c0);
        chk("clamp_err_clr", int'(err_clamp), 0);
        e.n = 7; e.cyc = c0 + 2; sb.push_back(e);
        wait_empty("clamp7_wait");

        // sweep up 4 -> 6
        issue(4, 1'b1, 6, c0);
        e.n = 4; e.cyc = c0 + 7;           sb.push_back(e);
        e.n = 5; e.cyc = c0 + 7 + 16;      sb.push_back(e);
        e.n = 6; e.cyc = c0 + 7 + 16 + 20; sb.push_back(e);
        wait_empty("sweep_up_wait");
        chk("sweep_up_busy", int'(busy), 0);
        measure_period("sweep_up_period", 6);

        // sweep down 6 -> 4 (start equals current ratio, so no visible first step)
        issue(6, 1'b1, 4, c0);
        e.n = 5; e.cyc = c0 + 6 + 24;      sb.push_back(e);
        e.n = 4; e.cyc = c0 + 6 + 24 + 20; sb.push_back(e);
        wait_empty("sweep_dn_wait");
        chk("sweep_dn_busy", int'(busy), 0);

        // abort a running sweep at n_out=5 on a boundary cycle
        issue(4, 1'b1, 6, c0);
        e.n = 5; e.cyc = c0 + 4 + 16; sb.push_back(e);
        wait_empty("abort_wait");
        chk("abort_pre_busy", int'(busy), 1);
        sync_boundary();
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_n_out", int'(n_out), 5);
        repeat (40) step();
        chk("abort_n_hold", int'(n_out), 5);

        // request ignored while busy, then reset mid-PEND drops the pending ratio
        issue(9, 1'b0, 0, c0);
        cfg_valid = 1'b1;
        cfg_n     = 8'd3;
        chk("busy_ready_low", int'(cfg_ready), 0);
        step();
        cfg_valid = 1'b0;
        chk("busy_still", int'(busy), 1);
        e.n = 2; e.cyc = c0 + 3; sb.push_back(e);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_n_out", int'(n_out), 2);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_err", int'(err_clamp), 0);
        repeat (40) step();
        chk("rstmid_n_hold", int'(n_out), 2);
        measure_period("rstmid_period", 2);

        chk("sb_leftover", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
